des_perm_pipe: RTL and testbench

DES_PERM_PIPE -- requirements
Module: des_perm_pipe

---
 rtl/des_pkg.sv | 37 +++
 rtl/des_perm64.sv | 30 +++
 rtl/des_perm_pipe.sv | 152 +++++++++++++++
 tb/tb_des_perm_pipe.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES definitions: mode encodings and the FP/IP bit-index tables.
// Table entries are DES bit numbers (1 = MSB of the 64-bit block).
package des_pkg;

    localparam logic MODE_FP = 1'b0;
    localparam logic MODE_IP = 1'b1;

    // Inverse initial permutation: output DES bit k takes input DES bit FP_TAB[k-1].
    localparam logic [6:0] FP_TAB [0:63] = '{
        7'd40, 7'd8,  7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7,  7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6,  7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5,  7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4,  7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3,  7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2,  7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1,  7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
    };

    // Initial permutation: output DES bit k takes input DES bit IP_TAB[k-1].
    localparam logic [6:0] IP_TAB [0:63] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    // DES bit n (1..64) lives at vector index 64-n.
    function automatic int des_bit_idx(input int n);
        return 64 - n;
    endfunction

endpackage

// File: rtl/des_perm64.sv
// Combinational DES FP/IP permutation: pure wiring per table, plus the mode select.
module des_perm64
    import des_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic        mode_i,
    output logic [63:0] data_o
);

    logic [63:0] fp_s;
    logic [63:0] ip_s;

    for (genvar k = 0; k < 64; k++) begin : g_bit
        localparam int FP_SRC = des_bit_idx(int'(FP_TAB[k]));
        localparam int IP_SRC = des_bit_idx(int'(IP_TAB[k]));
        assign fp_s[63-k] = data_i[FP_SRC];
        assign ip_s[63-k] = data_i[IP_SRC];
    end

    // Pick the permutation requested for this block.
    always_comb begin
        data_o = fp_s;
        case (mode_i)
            MODE_IP: data_o = ip_s;
            MODE_FP: data_o = fp_s;
            default: data_o = fp_s;
        endcase
    end

endmodule

// File: rtl/des_perm_pipe.sv
// DES FP/IP permutation with a valid/ready register pipeline, sideband tag,
// delivered-block counter and busy flag. Stages collapse bubbles: a stage
// loads whenever it is empty or its content moves on.
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] blk_count,
    output logic             busy
);

    localparam int LAST = PIPE_STAGES - 1;

    logic [63:0]                        perm_s;

    logic [PIPE_STAGES-1:0]             valid_q;
    logic [PIPE_STAGES-1:0]             valid_d;
    logic [PIPE_STAGES-1:0][63:0]       data_q;
    logic [PIPE_STAGES-1:0][63:0]       data_d;
    logic [PIPE_STAGES-1:0][TAG_W-1:0]  tag_q;
    logic [PIPE_STAGES-1:0][TAG_W-1:0]  tag_d;

    logic [PIPE_STAGES-1:0]             src_valid_s;
    logic [PIPE_STAGES-1:0][63:0]       src_data_s;
    logic [PIPE_STAGES-1:0][TAG_W-1:0]  src_tag_s;

    logic [PIPE_STAGES-1:0]             load_s;
    logic [PIPE_STAGES-1:0]             load_en_s;

    logic                               rdy_en_q;
    logic                               rdy_en_d;
    logic [CNT_W-1:0]                   cnt_q;
    logic [CNT_W-1:0]                   cnt_d;
    logic                               busy_q;
    logic                               busy_d;
    logic                               deliver_s;

    des_perm64 u_perm (
        .data_i (in_data),
        .mode_i (in_mode),
        .data_o (perm_s)
    );

    // Stage i may load when it or any stage after it is empty, or the sink is ready.
    always_comb begin
        load_s = '0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            load_s[i] = out_ready;
            for (int j = i; j < PIPE_STAGES; j++) begin
                load_s[i] = load_s[i] | ~valid_q[j];
            end
        end
    end

    // Stage 0 additionally waits for the post-reset ready enable.
    always_comb begin
        load_en_s    = load_s;
        load_en_s[0] = load_s[0] & rdy_en_q;
    end

    // What each stage would capture: the permuted input for stage 0, the previous stage otherwise.
    always_comb begin
        src_valid_s    = '0;
        src_data_s     = '0;
        src_tag_s      = '0;
        src_valid_s[0] = in_valid;
        src_data_s[0]  = perm_s;
        src_tag_s[0]   = in_tag;
        for (int i = 1; i < PIPE_STAGES; i++) begin
            src_valid_s[i] = valid_q[i-1];
            src_data_s[i]  = data_q[i-1];
            src_tag_s[i]   = tag_q[i-1];
        end
    end

    // Next state of every stage; payload only changes when a real block arrives.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            if (load_en_s[i]) begin
                valid_d[i] = src_valid_s[i];
                if (src_valid_s[i]) begin
                    data_d[i] = src_data_s[i];
                    tag_d[i]  = src_tag_s[i];
                end else begin
                    data_d[i] = data_q[i];
                    tag_d[i]  = tag_q[i];
                end
            end else begin
                valid_d[i] = valid_q[i];
                data_d[i]  = data_q[i];
                tag_d[i]   = tag_q[i];
            end
        end
    end

    assign deliver_s = valid_q[LAST] & out_ready;

    // Counter, busy flag and ready enable next-state.
    always_comb begin
        rdy_en_d = 1'b1;
        busy_d   = |valid_d;
        if (deliver_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // All state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            rdy_en_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            rdy_en_q <= rdy_en_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign in_ready  = load_en_s[0];
    assign out_valid = valid_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_tag   = tag_q[LAST];
    assign blk_count = cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed self-checking bench for des_perm_pipe (2 stages, 4-bit tag) plus a
// 4-bit-counter instance fed the same stimulus to observe counter wrap.
module tb_des_perm_pipe;

    localparam int PS = 2;
    localparam int TW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [TW-1:0] out_tag;
    logic [15:0]   blk_count;
    logic          busy;

    logic          in_ready_w;
    logic          out_valid_w;
    logic [63:0]   out_data_w;
    logic [TW-1:0] out_tag_w;
    logic [3:0]    blk_count_w;
    logic          busy_w;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    int fp_tab [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25
    };

    des_perm_pipe #(.PIPE_STAGES(PS), .TAG_W(TW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .blk_count(blk_count), .busy(busy)
    );

    des_perm_pipe #(.PIPE_STAGES(PS), .TAG_W(TW), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_tag(out_tag_w), .blk_count(blk_count_w), .busy(busy_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FP straight from the table; IP as its inverse (scatter instead of gather).
    function automatic logic [63:0] fp_model(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int k = 1; k <= 64; k++) r[64-k] = x[64-fp_tab[k-1]];
        return r;
    endfunction

    function automatic logic [63:0] ip_model(input logic [63:0] y);
        logic [63:0] r;
        r = '0;
        for (int k = 1; k <= 64; k++) r[64-fp_tab[k-1]] = y[64-k];
        return r;
    endfunction

    function automatic logic [63:0] bp_data(input int i);
        return {16'hA5A5, 16'(i), 32'hDEAD_BEEF ^ 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_data  = '0;
        in_tag   = '0;
        rst_n    = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    // Offer one block, then count edges (accepting edge = 1) until out_valid.
    task automatic send_single(input logic m, input logic [63:0] d, input logic [TW-1:0] t,
                               output logic [63:0] od, output logic [TW-1:0] ot, output int lat);
        int w;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_tag   = t;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        tick();
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_data  = '0;
        in_tag   = '0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        od = out_data;
        ot = out_tag;
        if (!out_valid) lat = 99;
    endtask

    // Stream n random blocks with alternating modes; score in order against the model.
    task automatic stream_blocks(input int n, output int got, output int gaps, output int bad);
        logic [63:0]   eq [$];
        logic [TW-1:0] tq [$];
        logic [63:0]   od;
        logic [TW-1:0] ot;
        logic          a;
        logic          dl;
        int            sent;
        int            cyc;
        int            last;
        sent = 0; got = 0; gaps = 0; bad = 0; cyc = 0; last = -1;
        while (got < n && cyc < n + 50) begin
            if (sent < n) begin
                in_valid = 1'b1;
                in_mode  = sent[0];
                in_data  = {$urandom(), $urandom()};
                in_tag   = sent[TW-1:0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            a  = in_valid && in_ready;
            dl = out_valid && out_ready;
            od = out_data;
            ot = out_tag;
            tick();
            if (a) begin
                eq.push_back(in_mode ? ip_model(in_data) : fp_model(in_data));
                tq.push_back(in_tag);
                sent++;
            end
            if (dl) begin
                if (eq.size() == 0) begin
                    bad++;
                end else begin
                    if (od !== eq[0] || ot !== tq[0]) bad++;
                    void'(eq.pop_front());
                    void'(tq.pop_front());
                end
                if (last >= 0 && cyc != last + 1) gaps++;
                last = cyc;
                got++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        bad = bad + eq.size();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
        chk_cnt++; if (blk_count !== 16'd0) $display("FAIL reset_blk_count: got %0d want 0", blk_count); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", in_ready); else pass_cnt++;
        chk_cnt++; if (out_data !== 64'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else pass_cnt++;
        chk_cnt++; if (out_tag !== 4'h0) $display("FAIL reset_out_tag: got %h want 0", out_tag); else pass_cnt++;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL release_in_ready_early: got %0b want 0", in_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %0b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_single_ip();
        logic [63:0] od; logic [TW-1:0] ot; int lat;
        send_single(1'b1, 64'h0123_4567_89AB_CDEF, 4'h3, od, ot, lat);
        chk_cnt++; if (od !== 64'hCC00_CCFF_F0AA_F0AA) $display("FAIL ip_data: got %h want cc00ccfff0aaf0aa", od); else pass_cnt++;
        chk_cnt++; if (ot !== 4'h3) $display("FAIL ip_tag: got %h want 3", ot); else pass_cnt++;
        chk_cnt++; if (lat != PS) $display("FAIL ip_latency: got %0d want %0d", lat, PS); else pass_cnt++;
        tick();
        chk_cnt++; if (blk_count !== 16'd1) $display("FAIL ip_blk_count: got %0d want 1", blk_count); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL ip_drained: got busy=%0b out_valid=%0b want 0/0", busy, out_valid); else pass_cnt++;
    endtask

    task automatic test_single_fp();
        logic [63:0] od; logic [TW-1:0] ot; int lat;
        send_single(1'b0, 64'hCC00_CCFF_F0AA_F0AA, 4'hA, od, ot, lat);
        chk_cnt++; if (od !== 64'h0123_4567_89AB_CDEF) $display("FAIL fp_data: got %h want 0123456789abcdef", od); else pass_cnt++;
        chk_cnt++; if (ot !== 4'hA) $display("FAIL fp_tag: got %h want a", ot); else pass_cnt++;
        chk_cnt++; if (lat != PS) $display("FAIL fp_latency: got %0d want %0d", lat, PS); else pass_cnt++;
        tick();
        // idle inputs wiggling with in_valid low must not create traffic
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0;
            in_mode  = i[0];
            in_data  = {$urandom(), $urandom()};
            in_tag   = 4'hF;
            tick();
        end
        in_data = '0; in_tag = '0; in_mode = 1'b0;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL idle_out_valid: got %0b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %0b want 0", busy); else pass_cnt++;
        chk_cnt++; if (blk_count !== 16'd2) $display("FAIL idle_blk_count: got %0d want 2", blk_count); else pass_cnt++;
    endtask

    task automatic test_vectors();
        logic [63:0] vin [6];
        logic        vmd [6];
        logic [63:0] vexp [6];
        logic [63:0] od; logic [TW-1:0] ot; int lat;
        vin[0] = 64'h8000_0000_0000_0000; vmd[0] = 1'b1; vexp[0] = 64'h0000_0000_0100_0000;
        vin[1] = 64'h8000_0000_0000_0000; vmd[1] = 1'b0; vexp[1] = 64'h0000_0000_0000_0040;
        vin[2] = 64'h0000_0000_0000_0001; vmd[2] = 1'b1; vexp[2] = 64'h0000_0080_0000_0000;
        vin[3] = 64'h0000_0000_0000_0001; vmd[3] = 1'b0; vexp[3] = 64'h0200_0000_0000_0000;
        vin[4] = 64'h0000_0000_0000_0000; vmd[4] = 1'b1; vexp[4] = 64'h0000_0000_0000_0000;
        vin[5] = 64'hFFFF_FFFF_FFFF_FFFF; vmd[5] = 1'b0; vexp[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            send_single(vmd[i], vin[i], 4'(i), od, ot, lat);
            tick();
            chk_cnt++;
            if (od !== vexp[i]) $display("FAIL vector_%0d: got %h want %h", i, od, vexp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stream();
        int got, gaps, bad;
        do_reset();
        out_ready = 1'b1;
        stream_blocks(100, got, gaps, bad);
        chk_cnt++; if (got != 100) $display("FAIL stream_count: got %0d want 100", got); else pass_cnt++;
        chk_cnt++; if (bad != 0) $display("FAIL stream_data: got %0d bad blocks want 0", bad); else pass_cnt++;
        chk_cnt++; if (gaps != 0) $display("FAIL stream_rate: got %0d gaps want 0", gaps); else pass_cnt++;
        chk_cnt++; if (blk_count !== 16'd100) $display("FAIL stream_blk_count: got %0d want 100", blk_count); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [63:0]   eq [$];
        logic [TW-1:0] tq [$];
        logic [63:0]   held, od;
        logic [TW-1:0] held_t, ot;
        logic          a, dl;
        int            i, cyc, got, bad;
        do_reset();
        out_ready = 1'b0;
        i = 0; cyc = 0; got = 0; bad = 0;
        in_valid = 1'b1; in_mode = 1'b1; in_data = bp_data(0); in_tag = 4'd0;
        while (cyc < 10) begin
            @(negedge clk);
            a = in_ready;
            tick();
            if (!a) break;
            eq.push_back(in_mode ? ip_model(in_data) : fp_model(in_data));
            tq.push_back(in_tag);
            i++;
            in_mode = i[0] ? 1'b0 : 1'b1; in_data = bp_data(i); in_tag = 4'(i);
            cyc++;
        end
        chk_cnt++; if (i != PS) $display("FAIL bp_fill: got %0d accepted want %0d", i, PS); else pass_cnt++;
        held = out_data;
        held_t = out_tag;
        chk_cnt++; if (held !== ip_model(bp_data(0))) $display("FAIL bp_head: got %h want %h", held, ip_model(bp_data(0))); else pass_cnt++;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held || out_tag !== held_t)
                $display("FAIL bp_stall_%0d: got rdy=%0b ov=%0b data=%h want 0/1/%h", s, in_ready, out_valid, out_data, held);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_full_accept: got %0b want 1", in_ready); else pass_cnt++;
        cyc = 0;
        while (got < 4 && cyc < 30) begin
            @(negedge clk);
            a  = in_valid && in_ready;
            dl = out_valid && out_ready;
            od = out_data;
            ot = out_tag;
            tick();
            if (a) begin
                eq.push_back(in_mode ? ip_model(in_data) : fp_model(in_data));
                tq.push_back(in_tag);
                i++;
                if (i < 4) begin
                    in_mode = i[0] ? 1'b0 : 1'b1; in_data = bp_data(i); in_tag = 4'(i);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (dl) begin
                if (eq.size() == 0) bad++;
                else begin
                    if (od !== eq[0] || ot !== tq[0]) bad++;
                    void'(eq.pop_front());
                    void'(tq.pop_front());
                end
                got++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk_cnt++; if (got != 4) $display("FAIL bp_drain_count: got %0d want 4", got); else pass_cnt++;
        chk_cnt++; if (bad != 0) $display("FAIL bp_drain_data: got %0d bad want 0", bad); else pass_cnt++;
        chk_cnt++; if (blk_count !== 16'd4) $display("FAIL bp_blk_count: got %0d want 4", blk_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] od; logic [TW-1:0] ot; int lat, acc; logic seen;
        do_reset();
        out_ready = 1'b1;
        send_single(1'b1, 64'h0123_4567_89AB_CDEF, 4'h5, od, ot, lat);
        tick();
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_mode = c[0]; in_data = bp_data(c + 10); in_tag = 4'(c + 7);
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk_cnt++; if (acc != 2) $display("FAIL mid_accept: got %0d want 2", acc); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1 || blk_count !== 16'd1) $display("FAIL mid_before: got busy=%0b cnt=%0d want 1/1", busy, blk_count); else pass_cnt++;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %0b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %0b want 0", busy); else pass_cnt++;
        chk_cnt++; if (blk_count !== 16'd0) $display("FAIL mid_blk_count: got %0d want 0", blk_count); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0 || out_data !== 64'h0) $display("FAIL mid_ready_data: got rdy=%0b data=%h want 0/0", in_ready, out_data); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk_cnt++; if (seen !== 1'b0) $display("FAIL mid_ghost: got out_valid seen=%0b want 0", seen); else pass_cnt++;
        chk_cnt++; if (blk_count !== 16'd0) $display("FAIL mid_after_count: got %0d want 0", blk_count); else pass_cnt++;
        tick();
    endtask

    task automatic test_wrap();
        int got, gaps, bad;
        do_reset();
        out_ready = 1'b1;
        stream_blocks(17, got, gaps, bad);
        chk_cnt++; if (got != 17 || bad != 0) $display("FAIL wrap_traffic: got %0d blocks %0d bad want 17/0", got, bad); else pass_cnt++;
        chk_cnt++; if (blk_count !== 16'd17) $display("FAIL wrap_wide_count: got %0d want 17", blk_count); else pass_cnt++;
        chk_cnt++; if (blk_count_w !== 4'd1) $display("FAIL wrap_count: got %0d want 1", blk_count_w); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_ip();
        test_single_fp();
        test_vectors();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
